// File: rtl/mor1kx_bus_arbiter_espresso.sv
// Shares one bus master port between the espresso fetch unit (ibus) and the LSU (dbus).
// Latency: request seen in IDLE at cycle N -> registered bus_req_o at N+1; ack/err routed back combinationally.
// Backpressure: a loser keeps its req high until IDLE; grants hold until ack/err. Optional MOR1KX_ARB_TIMEOUT_EN.
module mor1kx_bus_arbiter_espresso #(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int TIMEOUT_CYCLES       = 255
) (
   input  logic                            clk,
   input  logic                            rst,
   // fetch port
   input  logic                            ibus_req_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_i,
   output logic                            ibus_ack_o,
   output logic                            ibus_err_o,
   output logic [31:0]                     ibus_dat_o,
   // LSU port
   input  logic                            dbus_req_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_i,
   input  logic                            dbus_we_i,
   input  logic [3:0]                      dbus_bsel_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i,
   output logic                            dbus_ack_o,
   output logic                            dbus_err_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o,
   // shared bus master port
   output logic                            bus_req_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] bus_adr_o,
   output logic                            bus_we_o,
   output logic [3:0]                      bus_bsel_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_o,
   input  logic                            bus_ack_i,
   input  logic                            bus_err_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i
);

   localparam int W = OPTION_OPERAND_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_IBUS  = 2'd1,
      ST_DBUS  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic           r_last_dbus;
   logic           w_last_dbus_nxt;
   logic           r_bus_req;
   logic           w_bus_req_nxt;
   logic [W-1:0]   r_bus_adr;
   logic [W-1:0]   w_bus_adr_nxt;
   logic           r_bus_we;
   logic           w_bus_we_nxt;
   logic [3:0]     r_bus_bsel;
   logic [3:0]     w_bus_bsel_nxt;
   logic [W-1:0]   r_bus_dat;
   logic [W-1:0]   w_bus_dat_nxt;

   // Arbitration terms: dbus has priority unless it was served last and ibus is waiting,
   // which makes the two requesters alternate under continuous contention.
   logic           w_grant_dbus;
   logic           w_grant_ibus;
   // Any event that terminates the current access (bus response or forced timeout).
   logic           w_tmo_hit;
   logic           w_resp;
   // Response qualified for the owner: err (real or forced) always beats ack.
   logic           w_owner_ack;
   logic           w_owner_err;

   assign w_grant_dbus = dbus_req_i & ~(r_last_dbus & ibus_req_i);
   assign w_grant_ibus = ibus_req_i & ~w_grant_dbus;
   assign w_resp       = bus_ack_i | bus_err_i | w_tmo_hit;
   assign w_owner_ack  = bus_ack_i & ~bus_err_i & ~w_tmo_hit;
   assign w_owner_err  = bus_err_i | w_tmo_hit;

`ifdef MOR1KX_ARB_TIMEOUT_EN
   // Counter wide enough for TIMEOUT_CYCLES, never narrower than 8 bits.
   localparam int TMO_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;
   logic [TMO_W-1:0] r_tmo_cnt;

   // Count busy cycles without a response; cleared while idle so every grant starts from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (r_state == ST_IDLE) begin
         r_tmo_cnt <= '0;
      end else if (!(bus_ack_i | bus_err_i)) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   assign w_tmo_hit = (r_state != ST_IDLE) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
`else
   // No watchdog: an access waits for ack/err indefinitely.
   assign w_tmo_hit = 1'b0;
`endif

   // State and registered bus outputs; reset returns to IDLE and drops any outstanding access.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_last_dbus <= 1'b0;
         r_bus_req   <= 1'b0;
         r_bus_adr   <= '0;
         r_bus_we    <= 1'b0;
         r_bus_bsel  <= 4'h0;
         r_bus_dat   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_last_dbus <= w_last_dbus_nxt;
         r_bus_req   <= w_bus_req_nxt;
         r_bus_adr   <= w_bus_adr_nxt;
         r_bus_we    <= w_bus_we_nxt;
         r_bus_bsel  <= w_bus_bsel_nxt;
         r_bus_dat   <= w_bus_dat_nxt;
      end
   end

   // Next-state, grant latching and response routing to the current owner.
   always_comb begin
      w_state_nxt     = r_state;
      w_last_dbus_nxt = r_last_dbus;
      w_bus_req_nxt   = r_bus_req;
      w_bus_adr_nxt   = r_bus_adr;
      w_bus_we_nxt    = r_bus_we;
      w_bus_bsel_nxt  = r_bus_bsel;
      w_bus_dat_nxt   = r_bus_dat;
      ibus_ack_o      = 1'b0;
      ibus_err_o      = 1'b0;
      dbus_ack_o      = 1'b0;
      dbus_err_o      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // Responses seen here are spurious and never forwarded.
            if (w_grant_dbus) begin
               w_state_nxt     = ST_DBUS;
               w_bus_req_nxt   = 1'b1;
               w_bus_adr_nxt   = dbus_adr_i;
               w_bus_we_nxt    = dbus_we_i;
               w_bus_bsel_nxt  = dbus_bsel_i;
               w_bus_dat_nxt   = dbus_dat_i;
               w_last_dbus_nxt = 1'b1;
            end else if (w_grant_ibus) begin
               w_state_nxt     = ST_IBUS;
               w_bus_req_nxt   = 1'b1;
               w_bus_adr_nxt   = ibus_adr_i;
               w_bus_we_nxt    = 1'b0;
               w_bus_bsel_nxt  = 4'hf;
               w_bus_dat_nxt   = '0;
               w_last_dbus_nxt = 1'b0;
            end
         end

         ST_IBUS: begin
            ibus_ack_o = w_owner_ack;
            ibus_err_o = w_owner_err;
            if (w_resp) begin
               // Always pass through IDLE so the fetch PC can advance before the next grant.
               w_state_nxt   = ST_IDLE;
               w_bus_req_nxt = 1'b0;
            end else if (!ibus_req_i) begin
               // Fetch abandoned the access (branch): finish it silently on the bus.
               w_state_nxt = ST_DRAIN;
            end
         end

         ST_DBUS: begin
            dbus_ack_o = w_owner_ack;
            dbus_err_o = w_owner_err;
            if (w_resp) begin
               w_state_nxt   = ST_IDLE;
               w_bus_req_nxt = 1'b0;
            end else if (!dbus_req_i) begin
               w_state_nxt = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // Address/data stay latched; the response is swallowed.
            if (w_resp) begin
               w_state_nxt   = ST_IDLE;
               w_bus_req_nxt = 1'b0;
            end
         end

         default: begin
            w_state_nxt   = ST_IDLE;
            w_bus_req_nxt = 1'b0;
         end
      endcase

      // A response arriving in the reset cycle belongs to an access being dropped.
      if (rst) begin
         ibus_ack_o = 1'b0;
         ibus_err_o = 1'b0;
         dbus_ack_o = 1'b0;
         dbus_err_o = 1'b0;
      end
   end

   assign bus_req_o  = r_bus_req;
   assign bus_adr_o  = r_bus_adr;
   assign bus_we_o   = r_bus_we;
   assign bus_bsel_o = r_bus_bsel;
   assign bus_dat_o  = r_bus_dat;

   // Read data is a plain copy of the bus; requesters qualify it with their own ack.
   assign ibus_dat_o = bus_dat_i[31:0];
   assign dbus_dat_o = bus_dat_i;

endmodule

// File: tb/tb_mor1kx_bus_arbiter_espresso.sv
// Self-checking bench for the espresso bus arbiter: directed scenarios plus random traffic.
// Every cycle the DUT outputs are compared with a transaction-level model of the arbitration rules.
// Stimulus is applied just after the rising edge and sampled 2ns later, well away from either edge.
`timescale 1ns/1ps
module tb_mor1kx_bus_arbiter_espresso;

   localparam int W   = 32;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ibus_req_i = 1'b0;
   logic [W-1:0]  ibus_adr_i = '0;
   logic          ibus_ack_o, ibus_err_o;
   logic [31:0]   ibus_dat_o;
   logic          dbus_req_i = 1'b0;
   logic [W-1:0]  dbus_adr_i = '0;
   logic          dbus_we_i = 1'b0;
   logic [3:0]    dbus_bsel_i = 4'h0;
   logic [W-1:0]  dbus_dat_i = '0;
   logic          dbus_ack_o, dbus_err_o;
   logic [W-1:0]  dbus_dat_o;
   logic          bus_req_o, bus_we_o;
   logic [W-1:0]  bus_adr_o, bus_dat_o;
   logic [3:0]    bus_bsel_o;
   logic          bus_ack_i = 1'b0;
   logic          bus_err_i = 1'b0;
   logic [W-1:0]  bus_dat_i = '0;

   always #5 clk = ~clk;

   mor1kx_bus_arbiter_espresso #(
      .OPTION_OPERAND_WIDTH(W),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .ibus_req_i(ibus_req_i), .ibus_adr_i(ibus_adr_i),
      .ibus_ack_o(ibus_ack_o), .ibus_err_o(ibus_err_o), .ibus_dat_o(ibus_dat_o),
      .dbus_req_i(dbus_req_i), .dbus_adr_i(dbus_adr_i), .dbus_we_i(dbus_we_i),
      .dbus_bsel_i(dbus_bsel_i), .dbus_dat_i(dbus_dat_i),
      .dbus_ack_o(dbus_ack_o), .dbus_err_o(dbus_err_o), .dbus_dat_o(dbus_dat_o),
      .bus_req_o(bus_req_o), .bus_adr_o(bus_adr_o), .bus_we_o(bus_we_o),
      .bus_bsel_o(bus_bsel_o), .bus_dat_o(bus_dat_o),
      .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_dat_i(bus_dat_i)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one outstanding access at most, described by who owns it,
   // whether the owner walked away from it, and how long it has waited.
   logic          m_valid  = 1'b0;
   logic          m_busy   = 1'b0;
   logic          m_is_d   = 1'b0;
   logic          m_aband  = 1'b0;
   logic          m_last_d = 1'b0;
   int            m_wait   = 0;
   logic [W-1:0]  m_adr = '0, m_dat = '0;
   logic          m_we = 1'b0;
   logic [3:0]    m_bsel = 4'h0;

   // Owner-visible responses observed in the most recent cycle.
   logic c_iack = 1'b0, c_ierr = 1'b0, c_dack = 1'b0, c_derr = 1'b0;

   task automatic step(input logic r, input logic ir, input logic [W-1:0] ia,
                       input logic dr, input logic [W-1:0] da, input logic dw,
                       input logic [3:0] db, input logic [W-1:0] dd,
                       input logic ak, input logic er, input logic [W-1:0] bd);
      logic tmo_hit, act, fin;
      rst = r; ibus_req_i = ir; ibus_adr_i = ia;
      dbus_req_i = dr; dbus_adr_i = da; dbus_we_i = dw; dbus_bsel_i = db; dbus_dat_i = dd;
      bus_ack_i = ak; bus_err_i = er; bus_dat_i = bd;
      #2;
      tmo_hit = 1'b0;
`ifdef MOR1KX_ARB_TIMEOUT_EN
      tmo_hit = m_busy && (m_wait == TMO);
`endif
      act = m_valid && m_busy && !m_aband && !r;
      c_iack = ibus_ack_o; c_ierr = ibus_err_o; c_dack = dbus_ack_o; c_derr = dbus_err_o;
      check_val("ibus_ack", ibus_ack_o, act && !m_is_d && ak && !er && !tmo_hit);
      check_val("ibus_err", ibus_err_o, act && !m_is_d && (er || tmo_hit));
      check_val("dbus_ack", dbus_ack_o, act && m_is_d && ak && !er && !tmo_hit);
      check_val("dbus_err", dbus_err_o, act && m_is_d && (er || tmo_hit));
      check_val("ibus_dat", ibus_dat_o, bd);
      check_val("dbus_dat", dbus_dat_o, bd);
      if (m_valid) begin
         check_val("bus_req", bus_req_o, m_busy);
         if (m_busy) begin
            check_val("bus_adr", bus_adr_o, m_adr);
            check_val("bus_we", bus_we_o, m_we);
            check_val("bus_bsel", bus_bsel_o, m_bsel);
            if (m_we) check_val("bus_dat", bus_dat_o, m_dat);
         end
      end
      // Advance the model to what the next clock edge should produce.
      if (r) begin
         m_valid = 1'b1; m_busy = 1'b0; m_last_d = 1'b0; m_aband = 1'b0; m_wait = 0;
      end else if (m_valid) begin
         if (!m_busy) begin
            if (dr && !(m_last_d && ir)) begin
               m_busy = 1'b1; m_is_d = 1'b1; m_aband = 1'b0; m_wait = 0; m_last_d = 1'b1;
               m_adr = da; m_we = dw; m_bsel = db; m_dat = dd;
            end else if (ir) begin
               m_busy = 1'b1; m_is_d = 1'b0; m_aband = 1'b0; m_wait = 0; m_last_d = 1'b0;
               m_adr = ia; m_we = 1'b0; m_bsel = 4'hf;
            end
         end else begin
            fin = ak || er || tmo_hit;
            if (fin) m_busy = 1'b0;
            else begin
               if (!m_aband && !(m_is_d ? dr : ir)) m_aband = 1'b1;
               m_wait++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] q_adr[$];
      logic [W-1:0] exp_order[4];
      logic         prev_req, ak, er, r, i_done, d_done;
      logic         ir_s, dr_s, dw_s;
      logic [W-1:0] ia_s, da_s, dd_s;
      logic [3:0]   db_s;
      int           err_pulses;

      @(posedge clk); #1;
      // Reset state
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_val("rst_bus_req", bus_req_o, 0);
      check_val("rst_bus_adr", bus_adr_o, 0);
      check_val("rst_bus_we", bus_we_o, 0);
      check_val("rst_bus_bsel", bus_bsel_o, 0);
      check_val("rst_bus_dat", bus_dat_o, 0);

      // Lone fetch at 0x100, acked the cycle after bus_req_o rises
      step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 32'h1111);
      check_val("i_grant_req", bus_req_o, 1);
      check_val("i_grant_adr", bus_adr_o, 32'h100);
      check_val("i_grant_we", bus_we_o, 0);
      check_val("i_grant_bsel", bus_bsel_o, 4'hf);
      step(0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h1234_5678);
      check_val("i_ack_pulse", c_iack, 1);
      check_val("i_ack_no_d", c_dack, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_val("i_ack_one_cycle", c_iack, 0);
      check_val("i_done_req", bus_req_o, 0);

      // Continuous contention from reset: grants alternate dbus, ibus, dbus, ibus
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         prev_req = bus_req_o;
         step(0, 1, 32'h1000, 1, 32'h2000, 0, 4'hf, 0, m_busy, 0, 0);
         if (bus_req_o && !prev_req) q_adr.push_back(bus_adr_o);
         check_val("alt_req", bus_req_o, (k % 2 == 0) ? 1 : 0);
      end
      exp_order[0] = 32'h2000; exp_order[1] = 32'h1000;
      exp_order[2] = 32'h2000; exp_order[3] = 32'h1000;
      check_val("alt_count", q_adr.size(), 4);
      for (int k = 0; k < 4; k++)
         check_val("alt_order", (k < q_adr.size()) ? q_adr[k] : 32'hffff_ffff, exp_order[k]);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // dbus write; inputs changed after the grant must not reach the bus
      step(0, 0, 0, 1, 32'h2004, 1, 4'h3, 32'hdeadbeef, 0, 0, 0);
      step(0, 0, 0, 1, 32'h9990, 0, 4'hc, 32'h0, 0, 0, 0);
      check_val("dw_adr", bus_adr_o, 32'h2004);
      check_val("dw_dat", bus_dat_o, 32'hdeadbeef);
      check_val("dw_bsel", bus_bsel_o, 4'h3);
      check_val("dw_we", bus_we_o, 1);
      step(0, 0, 0, 1, 32'h9990, 0, 4'hc, 32'h0, 1, 0, 0);
      check_val("dw_ack", c_dack, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Fetch abandons its access: drained silently, pending dbus waits for IDLE
      step(0, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h400, 0, 4'hf, 0, 0, 0, 0);
      check_val("drain_adr_hold", bus_adr_o, 32'h300);
      step(0, 0, 0, 1, 32'h400, 0, 4'hf, 0, 0, 0, 0);
      check_val("drain_adr_hold2", bus_adr_o, 32'h300);
      step(0, 0, 0, 1, 32'h400, 0, 4'hf, 0, 1, 0, 0);
      check_val("drain_no_iack", c_iack, 0);
      check_val("drain_no_dack", c_dack, 0);
      check_val("drain_end_req", bus_req_o, 0);
      step(0, 0, 0, 1, 32'h400, 0, 4'hf, 0, 0, 0, 0);
      check_val("after_drain_req", bus_req_o, 1);
      check_val("after_drain_adr", bus_adr_o, 32'h400);
      step(0, 0, 0, 1, 32'h400, 0, 4'hf, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // ack and err together on a dbus read: err wins
      step(0, 0, 0, 1, 32'h500, 0, 4'hf, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h500, 0, 4'hf, 0, 1, 1, 32'hcafe);
      check_val("ae_err", c_derr, 1);
      check_val("ae_ack", c_dack, 0);
      check_val("ae_idle", bus_req_o, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Unanswered fetch
      step(0, 1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0);
      err_pulses = 0;
`ifdef MOR1KX_ARB_TIMEOUT_EN
      for (int k = 0; k < TMO; k++) begin
         step(0, 1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0);
         if (c_ierr) err_pulses++;
      end
      check_val("tmo_not_early", err_pulses, 0);
      step(0, 1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0);
      check_val("tmo_err", c_ierr, 1);
      check_val("tmo_req_drop", bus_req_o, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`else
      for (int k = 0; k < 110; k++) begin
         step(0, 1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0);
         if (c_ierr) err_pulses++;
      end
      check_val("notmo_req_held", bus_req_o, 1);
      check_val("notmo_no_err", err_pulses, 0);
      step(0, 1, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0);
      check_val("notmo_final_ack", c_iack, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

      // Random traffic with branches, spurious responses and occasional resets
      ir_s = 0; dr_s = 0; ia_s = 0; da_s = 0; dw_s = 0; db_s = 4'hf; dd_s = 0;
      i_done = 0; d_done = 0;
      for (int k = 0; k < 3000; k++) begin
         if (!ir_s || i_done) begin
            ir_s = 1'($urandom_range(1)); ia_s = $urandom & 32'hffff_fffc;
         end else if ($urandom_range(15) == 0) ir_s = 1'b0;
         if (!dr_s || d_done) begin
            dr_s = 1'($urandom_range(1)); da_s = $urandom; dw_s = 1'($urandom_range(1));
            db_s = 4'($urandom_range(15, 1)); dd_s = $urandom;
         end else if ($urandom_range(31) == 0) dr_s = 1'b0;
         if (m_busy) begin
            ak = ($urandom_range(2) == 0); er = ($urandom_range(9) == 0);
         end else begin
            ak = ($urandom_range(9) == 0); er = ($urandom_range(19) == 0);
         end
         r = ($urandom_range(299) == 0);
         step(r, ir_s, ia_s, dr_s, da_s, dw_s, db_s, dd_s, ak, er, $urandom);
         i_done = c_iack | c_ierr;
         d_done = c_dack | c_derr;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
